// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, diff = a - b, LSB first
//
// Purpose: computes a - b one bit per clock with a single full-subtractor cell
// and a borrow flip-flop. Operands are taken over a valid/ready handshake, and
// the result is offered over a valid/ready handshake.
//
// Optional feature macro: SERIAL_SUB_OVF_EN (adds the signed overflow output)
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous reset, active-high
//   in_valid   in   operand pair a/b is valid
//   in_ready   out  operands accepted (high only in IDLE)
//   a          in   minuend, WIDTH bits
//   b          in   subtrahend, WIDTH bits
//   out_valid  out  diff/borrow hold a finished result (DONE)
//   out_ready  in   downstream accepts the result
//   diff       out  a - b modulo 2^WIDTH
//   borrow     out  borrow out of the MSB cell (unsigned a < b)
//   overflow   out  signed overflow (only with SERIAL_SUB_OVF_EN)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Holds the WIDTH-1 bits produced so far; the final bit is merged
  // combinationally on the last RUN cycle so no spare register bit is needed.
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_br_next;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res_cat;

  assign w_a0      = r_a[0];
  assign w_b0      = r_b[0];
  assign w_d       = w_a0 ^ w_b0 ^ r_br;
  assign w_br_next = (~w_a0 & w_b0) | (~w_a0 & r_br) | (w_b0 & r_br);
  assign w_res_cat = {w_d, r_res};

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CW'(1);
      r_res <= w_res_cat[WIDTH-1:1];
      // Output registers change only when a result completes, so diff keeps
      // the previous result through IDLE and RUN.
      if (w_last) begin
        r_diff   <= w_res_cat;
        r_borrow <= w_br_next;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // The operand shift registers are consumed during RUN, so the original
  // sign bits are kept separately for the overflow decision.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      // w_d is the result MSB on the last RUN cycle.
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign overflow = r_ovf;
`endif

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign borrow    = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;
`endif

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             br;
    logic             ov;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  vec_t tbl[9];

  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result scoreboard: compare whenever a result handshake is about to occur.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: diff 0x%0h with no expected entry", diff);
      end else begin
        mon_e = q.pop_front();
        check("diff", {56'd0, diff}, {56'd0, mon_e.d});
        check("borrow", {63'd0, borrow}, {63'd0, mon_e.br});
`ifdef SERIAL_SUB_OVF_EN
        check("overflow", {63'd0, overflow}, {63'd0, mon_e.ov});
`endif
      end
    end
  end

  task automatic send(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                      input logic [WIDTH-1:0] ed, input logic ebr, input logic eov);
    int t;
    exp_t e;
    a = ia;
    b = ib;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    e.d = ed;
    e.br = ebr;
    e.ov = eov;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the acceptance edge; edges are counted including it.
  task automatic wait_done(input string name);
    int   lat;
    logic ready_seen;
    lat = 1;
    ready_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) ready_seen = 1'b1;
      tick();
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(WIDTH + 1));
    check({name, "_in_ready_run"}, {63'd0, ready_seen}, 64'd0);
    check({name, "_in_ready_done"}, {63'd0, in_ready}, 64'd0);
  endtask

  task automatic idle_window(input string name);
    int spur;
    spur = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) spur++;
      tick();
    end
    check({name, "_no_out_valid"}, 64'(spur), 64'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] ed;
    int               sd;
    int               t;
    exp_t             e;

    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[5] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    tbl[6] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    tbl[7] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
    tbl[8] = '{8'hC3, 8'h3C, 8'h87, 1'b0, 1'b0};

    tick();
    tick();
    rst = 1'b0;

    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_diff", {56'd0, diff}, 64'd0);
    check("rst_borrow", {63'd0, borrow}, 64'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_overflow", {63'd0, overflow}, 64'd0);
`endif

    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].br, tbl[i].ov);
      wait_done("vec");
      tick();
    end

    for (int i = 0; i < 6; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      ed = ra - rb;
      sd = int'($signed(ra)) - int'($signed(rb));
      send(ra, rb, ed, (ra < rb), (sd < -128 || sd > 127));
      wait_done("rand");
      tick();
    end

    // Back-pressure in DONE.
    out_ready = 1'b0;
    send(8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1);
    wait_done("bp");
    for (int i = 0; i < 5; i++) begin
      check("bp_diff_stable", {56'd0, diff}, 64'h4B);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      if (i == 1) begin
        in_valid = 1'b1;
        a = 8'h11;
        b = 8'h22;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    idle_window("bp_ignored");
    check("diff_retained", {56'd0, diff}, 64'h4B);

    // Reset on the third RUN cycle aborts the operation.
    send(8'h5A, 8'h21, 8'h39, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check("abort_diff", {56'd0, diff}, 64'd0);
    check("abort_borrow", {63'd0, borrow}, 64'd0);
    idle_window("abort");
    send(8'h10, 8'h10, 8'h00, 1'b0, 1'b0);
    wait_done("after_rst");
    tick();

    // Back-to-back with in_valid held high.
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check("b2b_first_ready", {63'd0, in_ready}, 64'd1);
    e.d = 8'h00;
    e.br = 1'b0;
    e.ov = 1'b0;
    q.push_back(e);
    tick();
    a = 8'h00;
    b = 8'hFF;
    t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    check("b2b_spacing", 64'(t + 1), 64'(WIDTH + 2));
    e.d = 8'h01;
    e.br = 1'b1;
    e.ov = 1'b0;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    wait_done("b2b");
    tick();
    tick();

    check("queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
